ghash_tag_checker: RTL and testbench

Receive-side GCM authentication block. It accumulates GHASH over the incoming AAD/ciphertext blocks and the final length block using a digit-serial GF(2^128) multiplier. It then forms the tag as GHASH ⊕ E(K,Y0) and compares it against the received tag. It sits after the decrypt datapath, next to the transmit-side GHASH core, and produces a single pass/fail verdict per message.

---
 rtl/ghash_tag_checker.sv | 192 +++++++++++++++++++
 tb/tb_ghash_tag_checker.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_tag_checker.sv
// ghash_tag_checker
//
// Receive-side GCM authentication. GHASH is accumulated over the AAD,
// ciphertext and final length blocks with a digit-serial GF(2^128)
// multiplier. The tag GHASH ^ E(K,Y0) is then compared with the received
// tag, and one pass/fail verdict is produced per message.
//
// Ports:
//   i_clock   - clock, rising edge
//   i_reset   - synchronous reset, active low
//   i_start   - one-cycle pulse: clear accumulator, sample H and E(K,Y0)
//   i_h_key   - hash subkey H
//   i_ek_y0   - E(K,Y0)
//   i_data_x  - AAD / ciphertext / length block (zero padded)
//   i_valid   - i_data_x valid
//   i_last    - i_data_x is the len(A)||len(C) block
//   i_tag     - received tag, sampled with the accepted last block
//   o_ready   - a block can be accepted this cycle
//   o_done    - one-cycle verdict strobe
//   o_pass    - computed tag matched i_tag (held until i_start/reset)
//   o_tag     - computed tag, or 0 when the tag output is not built
//
// Build option:
//   GHASH_TAG_CHECKER_TAG_OUT_EN - when defined, o_tag is a register
//   loaded with the computed tag; otherwise o_tag is tied to 0.

module ghash_tag_checker #(
  parameter int NB_DATA  = 128,
  parameter int NB_DIGIT = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_h_key,
  input  logic [NB_DATA-1:0] i_ek_y0,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic               i_valid,
  input  logic               i_last,
  input  logic [NB_DATA-1:0] i_tag,
  output logic               o_ready,
  output logic               o_done,
  output logic               o_pass,
  output logic [NB_DATA-1:0] o_tag
);

  localparam int NB_CYC = NB_DATA / NB_DIGIT;
  localparam int CNT_W  = (NB_CYC > 1) ? $clog2(NB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_CYC - 1);
  // Reduction constant in GCM (reflected) bit order: x^128 = 1+x+x^2+x^7.
  localparam logic [NB_DATA-1:0] R_POLY = {8'hE1, {(NB_DATA-8){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    MULT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t             state_q;
  logic [NB_DATA-1:0] y_q;
  logic [NB_DATA-1:0] h_q;
  logic [NB_DATA-1:0] ek_q;
  logic [NB_DATA-1:0] tag_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] z_q;
  logic [NB_DATA-1:0] v_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q;
  logic               ready_q;
  logic               done_q;
  logic               pass_q;

  logic [NB_DATA-1:0] z_d;
  logic [NB_DATA-1:0] v_d;
  logic [NB_DATA-1:0] a_d;

  // One digit of the shift-and-add multiply, unrolled NB_DIGIT times.
  // The operand A is consumed from its top bit (the x^0 coefficient), so
  // after each cycle it is shifted left to bring the next digit up.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int j = 0; j < NB_DIGIT; j++) begin
      if (a_q[NB_DATA-1-j]) begin
        z_d = z_d ^ v_d;
      end
      v_d = (v_d >> 1) ^ (v_d[0] ? R_POLY : '0);
    end
    a_d = a_q << NB_DIGIT;
  end

`ifdef GHASH_TAG_CHECKER_TAG_OUT_EN
  logic [NB_DATA-1:0] otag_q;
  assign o_tag = otag_q;
`else
  assign o_tag = '0;
`endif

  // Control FSM and datapath registers. i_start has priority over every
  // state so an in-flight message is dropped without a verdict. o_ready
  // is registered and is high exactly while the FSM sits in WAIT.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      h_q     <= '0;
      ek_q    <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GHASH_TAG_CHECKER_TAG_OUT_EN
      otag_q  <= '0;
`endif
    end else if (i_start) begin
      state_q <= WAIT;
      y_q     <= '0;
      h_q     <= i_h_key;
      ek_q    <= i_ek_y0;
      tag_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GHASH_TAG_CHECKER_TAG_OUT_EN
      otag_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
        end
        WAIT: begin
          if (i_valid) begin
            a_q     <= y_q ^ i_data_x;
            z_q     <= '0;
            v_q     <= h_q;
            cnt_q   <= '0;
            last_q  <= i_last;
            if (i_last) begin
              tag_q <= i_tag;
            end
            ready_q <= 1'b0;
            state_q <= MULT;
          end
        end
        MULT: begin
          z_q <= z_d;
          v_q <= v_d;
          a_q <= a_d;
          if (cnt_q == CNT_LAST) begin
            // Final digit: the product becomes the new accumulator.
            y_q   <= z_d;
            cnt_q <= '0;
            if (last_q) begin
              state_q <= CHECK;
            end else begin
              ready_q <= 1'b1;
              state_q <= WAIT;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          done_q  <= 1'b1;
          pass_q  <= ((y_q ^ ek_q) == tag_q);
`ifdef GHASH_TAG_CHECKER_TAG_OUT_EN
          otag_q  <= y_q ^ ek_q;
`endif
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_pass  = pass_q;

endmodule

// File: tb/tb_ghash_tag_checker.sv
// tb_ghash_tag_checker
//
// Bench for ghash_tag_checker. The main instance uses NB_DIGIT=8; two
// more instances (NB_DIGIT=1 and 128) share the stimulus and are used for
// the handshake-rate check. The reference GF(2^128) product is a plain
// carry-less polynomial multiply followed by reduction modulo
// x^128+x^7+x^2+x+1 on bit-reversed operands.

module tb_ghash_tag_checker;

  localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EK1  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C1   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] LEN2 = 128'h00000000000000000000000000000080;
  localparam logic [127:0] Y1   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] GH2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam int LAT8 = 17;

  logic         clock = 1'b0;
  logic         resetN;
  logic         start;
  logic [127:0] hKey;
  logic [127:0] ekY0;
  logic [127:0] dataX;
  logic         valid;
  logic         last;
  logic [127:0] tagIn;

  logic ready8, done8, pass8;
  logic ready1, done1, pass1;
  logic ready128, done128, pass128;
  logic [127:0] tag8, tag1, tag128;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  ghash_tag_checker #(.NB_DATA(128), .NB_DIGIT(8)) dut (
    .i_clock(clock), .i_reset(resetN), .i_start(start), .i_h_key(hKey),
    .i_ek_y0(ekY0), .i_data_x(dataX), .i_valid(valid), .i_last(last),
    .i_tag(tagIn), .o_ready(ready8), .o_done(done8), .o_pass(pass8),
    .o_tag(tag8)
  );

  ghash_tag_checker #(.NB_DATA(128), .NB_DIGIT(1)) dut1 (
    .i_clock(clock), .i_reset(resetN), .i_start(start), .i_h_key(hKey),
    .i_ek_y0(ekY0), .i_data_x(dataX), .i_valid(valid), .i_last(last),
    .i_tag(tagIn), .o_ready(ready1), .o_done(done1), .o_pass(pass1),
    .o_tag(tag1)
  );

  ghash_tag_checker #(.NB_DATA(128), .NB_DIGIT(128)) dut128 (
    .i_clock(clock), .i_reset(resetN), .i_start(start), .i_h_key(hKey),
    .i_ek_y0(ekY0), .i_data_x(dataX), .i_valid(valid), .i_last(last),
    .i_tag(tagIn), .o_ready(ready128), .o_done(done128), .o_pass(pass128),
    .o_tag(tag128)
  );

  // Reference model helpers

  function automatic logic [127:0] bitRev(input logic [127:0] a);
    logic [127:0] b;
    for (int i = 0; i < 128; i++) b[i] = a[127-i];
    return b;
  endfunction

  function automatic logic [127:0] gfMul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] a;
    logic [127:0] b;
    logic [254:0] p;
    logic [254:0] poly;
    a = bitRev(x);
    b = bitRev(y);
    p = '0;
    poly = (255'd1 << 128) | 255'h87;
    for (int i = 0; i < 128; i++) begin
      if (a[i]) p = p ^ (255'(b) << i);
    end
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) p = p ^ (poly << (i - 128));
    end
    return bitRev(p[127:0]);
  endfunction

  function automatic logic [127:0] tagView(input logic [127:0] t);
`ifdef GHASH_TAG_CHECKER_TAG_OUT_EN
    return t;
`else
    return '0;
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stimulus helpers

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseStart(input logic [127:0] h, input logic [127:0] ek);
    start = 1'b1;
    hKey = h;
    ekY0 = ek;
    tick();
    start = 1'b0;
  endtask

  task automatic sendBlock(input logic [127:0] d, input bit isLast,
                           input logic [127:0] t, output bit ok);
    int waitCnt;
    waitCnt = 0;
    dataX = d;
    last = isLast;
    tagIn = t;
    valid = 1'b1;
    while (!ready8 && waitCnt < 300) begin
      tick();
      waitCnt++;
    end
    ok = ready8;
    tick();
    valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!done8 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic waitReady(output bit ok);
    int n;
    n = 0;
    while (!ready8 && n < 300) begin
      tick();
      n++;
    end
    ok = ready8;
  endtask

  // Tests

  task automatic test_reset();
    resetN = 1'b0;
    tick();
    tick();
    nCompared++;
    if (ready8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b want 0", ready8); end
    nCompared++;
    if (done8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b want 0", done8); end
    nCompared++;
    if (pass8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_pass: got %b want 0", pass8); end
    nCompared++;
    if (tag8 !== 128'h0) begin nMismatched++; $display("[TB] FAIL reset_tag: got %h want 0", tag8); end
    nCompared++;
    if ({ready1, ready128} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_ready_others: got %b want 00", {ready1, ready128}); end
    resetN = 1'b1;
    tick();
    tick();
    nCompared++;
    if (ready8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_ready: got %b want 0", ready8); end
  endtask

  task automatic test_len_only();
    bit ok;
    int lat;
    logic [127:0] expTag;
    expTag = gfMul(128'h0, H1) ^ EK1;
    pulseStart(H1, EK1);
    sendBlock(128'h0, 1'b1, EK1, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL lenOnly_accept: got ready=%b want 1", ok); end
    waitDone(lat);
    nCompared++;
    if (lat != LAT8) begin nMismatched++; $display("[TB] FAIL lenOnly_latency: got %0d want %0d", lat, LAT8); end
    nCompared++;
    if (pass8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL lenOnly_pass: got %b want 1", pass8); end
    nCompared++;
    if (tag8 !== tagView(expTag)) begin nMismatched++; $display("[TB] FAIL lenOnly_tag: got %h want %h", tag8, tagView(expTag)); end
    tick();
    nCompared++;
    if (done8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL lenOnly_donePulse: got %b want 0", done8); end
    nCompared++;
    if (pass8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL lenOnly_passHold: got %b want 1", pass8); end
  endtask

  task automatic test_two_block(input bit flip);
    bit ok;
    int lat;
    int extraDone;
    logic expPass;
    expPass = ~flip;
    pulseStart(H1, EK1);
    sendBlock(C1, 1'b0, 128'h0, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL twoBlock_accept0: got ready=%b want 1", ok); end
    waitReady(ok);
    nCompared++;
    if (dut.y_q !== Y1) begin nMismatched++; $display("[TB] FAIL twoBlock_y1: got %h want %h", dut.y_q, Y1); end
    sendBlock(LEN2, 1'b1, TAG2 ^ {127'h0, flip}, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL twoBlock_accept1: got ready=%b want 1", ok); end
    waitDone(lat);
    nCompared++;
    if (lat != LAT8) begin nMismatched++; $display("[TB] FAIL twoBlock_latency: got %0d want %0d", lat, LAT8); end
    nCompared++;
    if (pass8 !== expPass) begin nMismatched++; $display("[TB] FAIL twoBlock_pass(flip=%0b): got %b want %b", flip, pass8, expPass); end
    nCompared++;
    if (dut.y_q !== GH2) begin nMismatched++; $display("[TB] FAIL twoBlock_ghash: got %h want %h", dut.y_q, GH2); end
    nCompared++;
    if (tag8 !== tagView(TAG2)) begin nMismatched++; $display("[TB] FAIL twoBlock_tag: got %h want %h", tag8, tagView(TAG2)); end
    extraDone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8) extraDone++;
    end
    nCompared++;
    if (extraDone != 0) begin nMismatched++; $display("[TB] FAIL twoBlock_singleDone: got %0d extra strobes want 0", extraDone); end
    nCompared++;
    if (pass8 !== expPass) begin nMismatched++; $display("[TB] FAIL twoBlock_passHold: got %b want %b", pass8, expPass); end
  endtask

  task automatic test_back_to_back();
    int xfer8[$];
    int xfer1[$];
    int xfer128[$];
    int doneSeen;
    int badGaps;
    pulseStart(rand128(), rand128());
    dataX = rand128();
    last = 1'b0;
    valid = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 600; c++) begin
      if (ready8) xfer8.push_back(c);
      if (ready1) xfer1.push_back(c);
      if (ready128) xfer128.push_back(c);
      if (done8 || done1 || done128) doneSeen++;
      tick();
    end
    valid = 1'b0;
    nCompared++;
    if (doneSeen != 0) begin nMismatched++; $display("[TB] FAIL b2b_noDone: got %0d strobes want 0", doneSeen); end

    nCompared++;
    if (xfer8.size() < 2 || xfer8[0] != 0) begin
      nMismatched++; $display("[TB] FAIL b2b_start_L16: got %0d transfers want first at cycle 0", xfer8.size());
    end
    badGaps = 0;
    for (int i = 1; i < xfer8.size(); i++) if (xfer8[i] - xfer8[i-1] != 17) badGaps++;
    nCompared++;
    if (badGaps != 0) begin nMismatched++; $display("[TB] FAIL b2b_gap_L16: got %0d bad gaps want 0 (gap 17)", badGaps); end

    nCompared++;
    if (xfer1.size() < 2 || xfer1[0] != 0) begin
      nMismatched++; $display("[TB] FAIL b2b_start_L128: got %0d transfers want first at cycle 0", xfer1.size());
    end
    badGaps = 0;
    for (int i = 1; i < xfer1.size(); i++) if (xfer1[i] - xfer1[i-1] != 129) badGaps++;
    nCompared++;
    if (badGaps != 0) begin nMismatched++; $display("[TB] FAIL b2b_gap_L128: got %0d bad gaps want 0 (gap 129)", badGaps); end

    nCompared++;
    if (xfer128.size() < 2 || xfer128[0] != 0) begin
      nMismatched++; $display("[TB] FAIL b2b_start_L1: got %0d transfers want first at cycle 0", xfer128.size());
    end
    badGaps = 0;
    for (int i = 1; i < xfer128.size(); i++) if (xfer128[i] - xfer128[i-1] != 2) badGaps++;
    nCompared++;
    if (badGaps != 0) begin nMismatched++; $display("[TB] FAIL b2b_gap_L1: got %0d bad gaps want 0 (gap 2)", badGaps); end
  endtask

  task automatic test_abort();
    bit ok;
    int doneSeen;
    pulseStart(H1, EK1);
    sendBlock(C1, 1'b0, 128'h0, ok);
    sendBlock(LEN2, 1'b1, TAG2, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL abort_accept: got ready=%b want 1", ok); end
    tick();
    tick();
    tick();
    pulseStart(H1, EK1);
    nCompared++;
    if (ready8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_ready: got %b want 1", ready8); end
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done8) doneSeen++;
      tick();
    end
    nCompared++;
    if (doneSeen != 0) begin nMismatched++; $display("[TB] FAIL abort_noDone: got %0d strobes want 0", doneSeen); end
    nCompared++;
    if (pass8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_passCleared: got %b want 0", pass8); end
    test_len_only();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int busy;
    pulseStart(H1, EK1);
    sendBlock(C1, 1'b0, 128'h0, ok);
    tick();
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    nCompared++;
    if ({ready8, done8, pass8} !== 3'b000) begin nMismatched++; $display("[TB] FAIL resetMid_flags: got %b want 000", {ready8, done8, pass8}); end
    nCompared++;
    if (tag8 !== 128'h0) begin nMismatched++; $display("[TB] FAIL resetMid_tag: got %h want 0", tag8); end
    nCompared++;
    if (dut.y_q !== 128'h0) begin nMismatched++; $display("[TB] FAIL resetMid_y: got %h want 0", dut.y_q); end
    valid = 1'b1;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready8 || done8) busy++;
    end
    valid = 1'b0;
    nCompared++;
    if (busy != 0) begin nMismatched++; $display("[TB] FAIL resetMid_idle: got %0d active cycles want 0", busy); end
    pulseStart(H1, EK1);
    nCompared++;
    if (ready8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL resetMid_restart: got %b want 1", ready8); end
  endtask

  task automatic test_random();
    bit ok;
    int lat;
    int nb;
    bit good;
    logic [127:0] h, ek, d, y, expTag, t;
    for (int m = 0; m < 8; m++) begin
      h = rand128();
      ek = rand128();
      nb = $urandom_range(0, 3);
      y = '0;
      pulseStart(h, ek);
      for (int b = 0; b < nb; b++) begin
        d = rand128();
        sendBlock(d, 1'b0, 128'h0, ok);
        y = gfMul(y ^ d, h);
      end
      d = rand128();
      y = gfMul(y ^ d, h);
      expTag = y ^ ek;
      good = 1'($urandom_range(0, 1));
      t = good ? expTag : (expTag ^ (128'd1 << $urandom_range(0, 127)));
      sendBlock(d, 1'b1, t, ok);
      nCompared++;
      if (!ok) begin nMismatched++; $display("[TB] FAIL rand%0d_accept: got ready=%b want 1", m, ok); end
      waitDone(lat);
      nCompared++;
      if (lat != LAT8) begin nMismatched++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", m, lat, LAT8); end
      nCompared++;
      if (pass8 !== good) begin nMismatched++; $display("[TB] FAIL rand%0d_pass: got %b want %b", m, pass8, good); end
      nCompared++;
      if (dut.y_q !== y) begin nMismatched++; $display("[TB] FAIL rand%0d_ghash: got %h want %h", m, dut.y_q, y); end
      nCompared++;
      if (tag8 !== tagView(expTag)) begin nMismatched++; $display("[TB] FAIL rand%0d_tag: got %h want %h", m, tag8, tagView(expTag)); end
    end
  endtask

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    start = 1'b0;
    hKey = '0;
    ekY0 = '0;
    dataX = '0;
    valid = 1'b0;
    last = 1'b0;
    tagIn = '0;
    #1;
    test_reset();
    test_len_only();
    test_two_block(1'b0);
    test_two_block(1'b1);
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
